// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// controller states, datapath mux encodings and instruction class indices.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
   localparam logic [1:0] PC_SEL_IMM   = 2'b01;
   localparam logic [1:0] PC_SEL_ALU   = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MDR = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // Bit positions of the one-hot instruction class vector.
   localparam int CLS_W      = 9;
   localparam int CLS_R      = 0;
   localparam int CLS_I_ALU  = 1;
   localparam int CLS_LOAD   = 2;
   localparam int CLS_STORE  = 3;
   localparam int CLS_BRANCH = 4;
   localparam int CLS_JAL    = 5;
   localparam int CLS_JALR   = 6;
   localparam int CLS_LUI    = 7;
   localparam int CLS_AUIPC  = 8;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag for any opcode the controller does not sequence.
module mc_opcode_decode
   import riscv_pkg::*;
(
   input  logic [6:0]       opcode,
   output logic [CLS_W-1:0] cls,
   output logic             illegal
);

   // Map each supported opcode to exactly one class bit.
   always_comb begin
      cls     = '0;
      illegal = 1'b0;
      case (opcode)
         OP_R:      cls[CLS_R]      = 1'b1;
         OP_I_ALU:  cls[CLS_I_ALU]  = 1'b1;
         OP_LOAD:   cls[CLS_LOAD]   = 1'b1;
         OP_STORE:  cls[CLS_STORE]  = 1'b1;
         OP_BRANCH: cls[CLS_BRANCH] = 1'b1;
         OP_JAL:    cls[CLS_JAL]    = 1'b1;
         OP_JALR:   cls[CLS_JALR]   = 1'b1;
         OP_LUI:    cls[CLS_LUI]    = 1'b1;
         OP_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
         default:   illegal         = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: drives datapath enables and mux selects,
// shares one memory port between fetch and data access, counts retired
// instructions and traps on illegal opcodes or a stalled memory.
// Control outputs are decoded from the current state (and mem_ready /
// take_branch where a same-cycle response is needed) and are forced low
// while reset is asserted so an in-flight request drops immediately.
module multicycle_controller
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             take_branch,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic [WD_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic [CLS_W-1:0]   cls;
   logic               dec_illegal;
   logic               wd_hit;
   logic               waiting;

   mc_opcode_decode u_decode (
      .opcode  (opcode),
      .cls     (cls),
      .illegal (dec_illegal)
   );

   // Next-state, datapath controls, retire and watchdog bookkeeping.
   always_comb begin
      state_d      = state_q;
      instret_d    = instret_q;
      illegal_d    = illegal_q;
      bus_err_d    = bus_err_q;
      wait_cnt_d   = wait_cnt_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_SEL_PLUS4;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_OP_ADD;
      reg_write    = 1'b0;
      wb_sel       = WB_SEL_ALU;

      // Watchdog fires once the counter has reached the limit and memory is still not ready.
      wd_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WD_W'(MEM_TIMEOUT)) && !mem_ready;

      // ALU setup is kept through MEM and WB so the address/result stays stable.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         if (cls[CLS_R]) begin
            alu_op = ALU_OP_FUNCT;
         end else if (cls[CLS_I_ALU]) begin
            alu_src_b = 1'b1;
            alu_op    = ALU_OP_FUNCT;
         end else if (cls[CLS_LOAD] || cls[CLS_STORE] || cls[CLS_JALR]) begin
            alu_src_b = 1'b1;
         end else if (cls[CLS_AUIPC]) begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
         end else if (cls[CLS_BRANCH]) begin
            alu_op = ALU_OP_SUB;
         end
      end

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (wd_hit) begin
               bus_err_d = 1'b1;
               state_d   = ST_TRAP;
            end
         end
         ST_DECODE: begin
            if (dec_illegal) begin
               illegal_d = 1'b1;
               state_d   = ST_TRAP;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cls[CLS_BRANCH]) begin
               pc_write  = 1'b1;
               pc_sel    = take_branch ? PC_SEL_IMM : PC_SEL_PLUS4;
               instret_d = instret_q + CNT_W'(1);
               state_d   = ST_FETCH;
            end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = cls[CLS_STORE];
            if (mem_ready) begin
               if (cls[CLS_STORE]) begin
                  pc_write  = 1'b1;
                  instret_d = instret_q + CNT_W'(1);
                  state_d   = ST_FETCH;
               end else begin
                  mdr_write = 1'b1;
                  state_d   = ST_WB;
               end
            end else if (wd_hit) begin
               bus_err_d = 1'b1;
               state_d   = ST_TRAP;
            end
         end
         ST_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (cls[CLS_LOAD]) begin
               wb_sel = WB_SEL_MDR;
            end else if (cls[CLS_JAL] || cls[CLS_JALR]) begin
               wb_sel = WB_SEL_PC4;
            end else if (cls[CLS_LUI]) begin
               wb_sel = WB_SEL_IMM;
            end
            if (cls[CLS_JAL]) begin
               pc_sel = PC_SEL_IMM;
            end else if (cls[CLS_JALR]) begin
               pc_sel = PC_SEL_ALU;
            end
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // Wait counter tracks consecutive stalled request cycles within one state.
      waiting = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
      if (state_d != state_q || mem_ready) begin
         wait_cnt_d = '0;
      end else if (waiting) begin
         wait_cnt_d = wait_cnt_q + WD_W'(1);
      end

      // Reset abandons any request in the same cycle.
      if (reset) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         ir_write     = 1'b0;
         mdr_write    = 1'b0;
         pc_write     = 1'b0;
         pc_sel       = 2'b00;
         alu_src_a    = 1'b0;
         alu_src_b    = 1'b0;
         alu_op       = 2'b00;
         reg_write    = 1'b0;
         wb_sel       = 2'b00;
      end
   end

   assign illegal = illegal_q & ~reset;
   assign bus_err = bus_err_q & ~reset;
   assign instret = reset ? '0 : instret_q;

   // State, sticky flags and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         instret_q  <= '0;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instret_q  <= instret_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multi-cycle RV32I datapath built from the existing PC, register file, ALU, immediate generator and branch comparator.
- Instruction fetch and data access share one unified memory port through a req/ready handshake.
- The block drives all datapath enables and mux selects.
- It maintains a retired-instruction counter and a memory-wait watchdog.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before bus error; 0 disables watchdog
CNT_W, 32, width of instret counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state on the clock edge
opcode  input  7  instruction[6:0] from instruction register (IR); stable from DECODE onward
take_branch  input  1  branch comparator result, valid in EXEC
mem_ready  input  1  memory accepted/completed current request this cycle
mem_req  output  1  memory request; held high with stable address until mem_ready
mem_we  output  1  write strobe, valid with mem_req
mem_addr_sel  output  1  0 = PC, 1 = ALU result
ir_write  output  1  load IR from memory read data
mdr_write  output  1  load memory-data register
pc_write  output  1  update PC
pc_sel  output  2  00 = PC+4, 01 = PC+imm, 10 = ALU result with bit0 cleared
alu_src_a  output  1  0 = rs1, 1 = PC
alu_src_b  output  1  0 = rs2, 1 = imm
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
reg_write  output  1  register file write enable
wb_sel  output  2  00 = ALU, 01 = MDR, 10 = PC+4, 11 = imm
illegal  output  1  sticky: unsupported opcode trapped
bus_err  output  1  sticky: memory watchdog expired
instret  output  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP (3-bit encoding).
- Unlisted outputs are 0 in each state.
- Reset:
  - Reset cycle: state <= FETCH, instret/illegal/bus_err/wait counter <= 0, all outputs forced 0.
  - Reset mid-operation aborts the instruction; mem_req drops in the reset cycle, and memory tolerates the abandoned request.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - When mem_ready: ir_write=1 (same cycle), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode -> TRAP, with illegal set on entry.
  - Supported opcode -> EXEC.
- EXEC (1 cycle), ALU settings by class:
  - R: alu_src_b=0, alu_op=10.
  - I-ALU: alu_src_b=1, alu_op=10.
  - LOAD/STORE/JALR: alu_src_b=1, alu_op=00.
  - AUIPC: alu_src_a=1, alu_src_b=1, alu_op=00.
  - BRANCH: alu_op=01.
  - JAL and LUI: no ALU work.
- EXEC next state and PC update:
  - BRANCH: pc_write=1, pc_sel = take_branch ? 01 : 00, retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
  - ALU settings are held in MEM and WB so the ALU result stays stable.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - When mem_ready on LOAD: mdr_write=1, go to WB.
  - When mem_ready on STORE: pc_write=1, pc_sel=00, retire, go to FETCH.
- WB (1 cycle):
  - reg_write=1 and pc_write=1.
  - wb_sel: LOAD 01; JAL/JALR 10; LUI 11; else 00.
  - pc_sel: JAL 01; JALR 10; else 00.
  - Retire, go to FETCH.
- TRAP:
  - Absorbing state: all enables 0, no mem_req.
  - Left only by reset.
- Retire: instret increments by 1 on the retiring cycle and wraps modulo 2^CNT_W.
- Watchdog:
  - Counter increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: bus_err <= 1, next state TRAP.
  - mem_ready in the same cycle the limit is reached wins (normal completion, no error).
- Latency with zero-wait memory (mem_ready tied 1): BRANCH 3 cycles; R, I-ALU, LUI, AUIPC, JAL, JALR and STORE 4; LOAD 5.
- Each memory wait cycle adds 1.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - state enum;
  - pc_sel, wb_sel and alu_op encodings.
- One natural sub-module: mc_opcode_decode, a combinational opcode -> instruction class one-hot plus illegal flag.
- FSM, watchdog and instret counter stay in multicycle_controller.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> first post-reset cycle state FETCH, mem_req=1, mem_addr_sel=0, ir_write=1; instret=0.
- R-type (opcode 0110011), zero-wait -> reg_write=1 with wb_sel=00 in cycle 4, pc_write with pc_sel=00 the same cycle; instret 0 -> 1.
- LOAD with mem_ready low 3 cycles in MEM -> mem_req stays 1 with mem_addr_sel=1 for 4 cycles; mdr_write on the ready cycle; WB with wb_sel=01; total 8 cycles.
- BRANCH with take_branch=1, then =0 -> EXEC pc_write=1 with pc_sel=01, then 00; each retires in 3 cycles; no reg_write.
- Opcode 1110011, and MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> illegal=1 / bus_err=1, TRAP with all enables 0. Reset clears the flags and restarts FETCH. mem_ready arriving on the 4th wait cycle completes normally.
- Reset asserted during MEM of a STORE -> mem_req and mem_we drop the same cycle, no pc_write, instret unchanged, FETCH after release.
